// File: rtl/spi_pkg.sv
// Shared definitions for the SPI command/register controller and its neighbours.
package spi_pkg;

    localparam int unsigned SPI_BITS       = 8;
    localparam int unsigned SPI_ADDR_W     = 7;
    localparam int unsigned SPI_RD_TIMEOUT = 4;
    localparam int unsigned RW_BIT         = SPI_BITS - 1;

    localparam logic [SPI_BITS-1:0] STATUS_ID_DEF = 8'hA5;
    // Byte presented to the host when a read never returned data.
    localparam logic [SPI_BITS-1:0] FILL_BYTE     = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_WR      = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_RD      = 3'd4
    } spi_state_e;

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Byte-engine and register-bus signals of spi_reg_ctrl; master is the controller side.
interface spi_reg_ctrl_if #(
    parameter int unsigned BITS   = 8,
    parameter int unsigned ADDR_W = 7
);

    logic              ssel;
    logic              byte_received;
    logic [BITS-1:0]   rx_data;
    logic              data_needed;
    logic [BITS-1:0]   tx_data;
    logic [ADDR_W-1:0] reg_addr;
    logic [BITS-1:0]   reg_wdata;
    logic              reg_we;
    logic              reg_re;
    logic [BITS-1:0]   reg_rdata;
    logic              reg_rvalid;
    logic              busy;
    logic              err_timeout;

    modport master (
        input  ssel, byte_received, rx_data, data_needed, reg_rdata, reg_rvalid,
        output tx_data, reg_addr, reg_wdata, reg_we, reg_re, busy, err_timeout
    );

    modport slave (
        output ssel, byte_received, rx_data, data_needed, reg_rdata, reg_rvalid,
        input  tx_data, reg_addr, reg_wdata, reg_we, reg_re, busy, err_timeout
    );

endinterface

// File: rtl/spi_rd_fetch.sv
// Read prefetch: waits for reg_rvalid after a read strobe and loads the transmit byte,
// substituting the fill byte when the register file does not answer in time.
module spi_rd_fetch
    import spi_pkg::*;
#(
    parameter int unsigned     BITS       = SPI_BITS,
    parameter int unsigned     RD_TIMEOUT = SPI_RD_TIMEOUT,
    parameter logic [BITS-1:0] STATUS_ID  = STATUS_ID_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic            rvalid_i,
    input  logic [BITS-1:0] rdata_i,
    output logic            done_o,
    output logic            timeout_o,
    output logic [BITS-1:0] tx_data_o
);

    localparam int unsigned      CNT_W    = $clog2(RD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(RD_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic             active_q, active_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BITS-1:0]  tx_q, tx_d;
    logic             armed_s;

    // cnt_q == 0 is the strobe cycle itself, so rvalid is only honoured from one cycle later.
    assign armed_s = active_q && (cnt_q != CNT_ZERO);

    // Next-state for the wait counter and the transmit byte.
    always_comb begin
        active_d  = active_q;
        cnt_d     = cnt_q;
        tx_d      = tx_q;
        done_o    = 1'b0;
        timeout_o = 1'b0;
        if (abort_i) begin
            active_d = 1'b0;
            cnt_d    = CNT_ZERO;
            tx_d     = STATUS_ID;
        end else if (start_i) begin
            active_d = 1'b1;
            cnt_d    = CNT_ZERO;
        end else if (armed_s && rvalid_i) begin
            active_d = 1'b0;
            tx_d     = rdata_i;
            done_o   = 1'b1;
        end else if (armed_s && (cnt_q == CNT_MAX)) begin
            active_d  = 1'b0;
            tx_d      = {BITS{1'b1}};
            done_o    = 1'b1;
            timeout_o = 1'b1;
        end else if (active_q) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            cnt_q    <= CNT_ZERO;
            tx_q     <= STATUS_ID;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            tx_q     <= tx_d;
        end
    end

    assign tx_data_o = tx_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// Decodes SPI frames ({rw, addr} command byte, then data bytes) into register-bus
// writes and prefetched reads; read data is staged by spi_rd_fetch.
module spi_reg_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned     BITS       = SPI_BITS,
    parameter int unsigned     ADDR_W     = SPI_ADDR_W,
    parameter logic [BITS-1:0] STATUS_ID  = STATUS_ID_DEF,
    parameter int unsigned     RD_TIMEOUT = SPI_RD_TIMEOUT
) (
    input logic            clk,
    input logic            rst_n,
    spi_reg_ctrl_if.master bus
);

    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

    spi_state_e        state_q, state_d;
    logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
    logic [BITS-1:0]   reg_wdata_q, reg_wdata_d;
    logic              reg_we_q, reg_we_d;
    logic              reg_re_q, reg_re_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    logic              byte_ok_s;
    logic              rw_s;
    logic              fetch_start_s;
    logic              fetch_done_s;
    logic              fetch_tmo_s;
    logic [BITS-1:0]   tx_data_s;
    logic              unused_s;

    assign byte_ok_s     = bus.byte_received && !bus.ssel;
    assign rw_s          = bus.rx_data[RW_BIT];
    assign fetch_start_s = byte_ok_s && (((state_q == ST_CMD) && rw_s) ||
                                         (state_q == ST_RD) || (state_q == ST_RD_WAIT));
    assign unused_s      = bus.data_needed;

    spi_rd_fetch #(
        .BITS       (BITS),
        .RD_TIMEOUT (RD_TIMEOUT),
        .STATUS_ID  (STATUS_ID)
    ) u_rd_fetch (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (fetch_start_s),
        .abort_i   (bus.ssel),
        .rvalid_i  (bus.reg_rvalid),
        .rdata_i   (bus.reg_rdata),
        .done_o    (fetch_done_s),
        .timeout_o (fetch_tmo_s),
        .tx_data_o (tx_data_s)
    );

    // Frame FSM: next state, register-bus strobes, address and error flag.
    always_comb begin
        state_d     = state_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_we_d    = 1'b0;
        reg_re_d    = 1'b0;
        err_d       = err_q;
        if (bus.ssel) begin
            state_d = ST_IDLE;
        end else begin
            // Address advances only after the write strobe, so it is stable while reg_we is high.
            if (reg_we_q) begin
                reg_addr_d = reg_addr_q + ADDR_ONE;
            end else begin
                reg_addr_d = reg_addr_q;
            end
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_CMD;
                    err_d   = 1'b0;
                end
                ST_CMD: begin
                    if (byte_ok_s) begin
                        reg_addr_d = bus.rx_data[ADDR_W-1:0];
                        if (rw_s) begin
                            reg_re_d = 1'b1;
                            state_d  = ST_RD_WAIT;
                        end else begin
                            state_d = ST_WR;
                        end
                    end else begin
                        state_d = ST_CMD;
                    end
                end
                ST_WR: begin
                    if (byte_ok_s) begin
                        reg_wdata_d = bus.rx_data;
                        reg_we_d    = 1'b1;
                    end else begin
                        reg_we_d = 1'b0;
                    end
                end
                ST_RD_WAIT: begin
                    // A byte arriving before the fetch finished means the host outran us.
                    if (byte_ok_s) begin
                        reg_addr_d = reg_addr_q + ADDR_ONE;
                        reg_re_d   = 1'b1;
                        err_d      = 1'b1;
                    end else if (fetch_done_s) begin
                        state_d = ST_RD;
                        err_d   = err_q | fetch_tmo_s;
                    end else begin
                        state_d = ST_RD_WAIT;
                    end
                end
                ST_RD: begin
                    if (byte_ok_s) begin
                        reg_addr_d = reg_addr_q + ADDR_ONE;
                        reg_re_d   = 1'b1;
                        state_d    = ST_RD_WAIT;
                    end else begin
                        state_d = ST_RD;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        busy_d = (state_d != ST_IDLE);
    end

    // Controller state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            reg_addr_q  <= ADDR_ZERO;
            reg_wdata_q <= {BITS{1'b0}};
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_we_q    <= reg_we_d;
            reg_re_q    <= reg_re_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign bus.tx_data     = tx_data_s;
    assign bus.reg_addr    = reg_addr_q;
    assign bus.reg_wdata   = reg_wdata_q;
    assign bus.reg_we      = reg_we_q;
    assign bus.reg_re      = reg_re_q;
    assign bus.busy        = busy_q;
    assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl: byte-level SPI host, register-file responder
// with programmable read latency, and a frame-level reference model.
module tb_spi_reg_ctrl;

    typedef logic [7:0] bytes_t [16];

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spi_reg_ctrl_if #(.BITS(8), .ADDR_W(7)) bus ();

    spi_reg_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    int         rsp_delay = 2;
    int         rsp_cnt   = 0;
    logic [6:0] rsp_addr  = 7'd0;
    logic [7:0] rd_off    = 8'h40;

    logic [6:0] we_addr_q[$];
    logic [7:0] we_data_q[$];
    logic [6:0] re_addr_q[$];
    int         both_cnt = 0;

    function automatic logic [7:0] rd_val(input logic [6:0] a);
        return {1'b0, a} + rd_off;
    endfunction

    // Register file responder and bus monitor; rvalid comes rsp_delay cycles after reg_re (0 = never).
    always @(negedge clk) begin
        bus.reg_rvalid = 1'b0;
        if (rsp_cnt > 0) begin
            rsp_cnt = rsp_cnt - 1;
            if (rsp_cnt == 0) begin
                bus.reg_rvalid = 1'b1;
                bus.reg_rdata  = rd_val(rsp_addr);
            end
        end
        if (bus.reg_re === 1'b1) begin
            rsp_cnt  = rsp_delay;
            rsp_addr = bus.reg_addr;
            re_addr_q.push_back(bus.reg_addr);
        end
        if (bus.reg_we === 1'b1) begin
            we_addr_q.push_back(bus.reg_addr);
            we_data_q.push_back(bus.reg_wdata);
        end
        if ((bus.reg_we === 1'b1) && (bus.reg_re === 1'b1)) both_cnt++;
    end

    task automatic clear_mon();
        we_addr_q.delete();
        we_data_q.delete();
        re_addr_q.delete();
    endtask

    task automatic frame_begin();
        clear_mon();
        @(posedge clk); #1;
        bus.ssel = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic frame_end();
        repeat (3) @(posedge clk);
        #1 bus.ssel = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    // One SPI byte: sample what the slave would shift out, then report the received byte.
    task automatic xfer(input logic [7:0] b, input int gap, output logic [7:0] got);
        repeat (gap - 1) @(posedge clk);
        @(negedge clk);
        got = bus.tx_data;
        bus.data_needed = 1'b1;
        @(posedge clk); #1;
        bus.data_needed   = 1'b0;
        bus.byte_received = 1'b1;
        bus.rx_data       = b;
        @(posedge clk); #1;
        bus.byte_received = 1'b0;
    endtask

    task automatic run_frame(input int n, input bytes_t b, input int gap, output bytes_t got);
        logic [7:0] g;
        got = '{default: 8'h00};
        frame_begin();
        for (int i = 0; i < n; i++) begin
            xfer(b[i], gap, g);
            got[i] = g;
        end
        frame_end();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.tx_data !== 8'hA5) begin n_err++; $display("FAIL reset_tx got=%h exp=a5", bus.tx_data); end
        n_cmp++; if (bus.reg_addr !== 7'h00) begin n_err++; $display("FAIL reset_addr got=%h exp=00", bus.reg_addr); end
        n_cmp++; if (bus.reg_wdata !== 8'h00) begin n_err++; $display("FAIL reset_wdata got=%h exp=00", bus.reg_wdata); end
        n_cmp++; if ({bus.reg_we, bus.reg_re, bus.busy, bus.err_timeout} !== 4'b0000) begin
            n_err++; $display("FAIL reset_flags got=%b exp=0000", {bus.reg_we, bus.reg_re, bus.busy, bus.err_timeout});
        end
    endtask

    task automatic test_busy();
        @(posedge clk); #1 bus.ssel = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL busy_pre_rise got=%b exp=0", bus.busy); end
        @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL busy_rise got=%b exp=1", bus.busy); end
        @(posedge clk); #1 bus.ssel = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL busy_pre_fall got=%b exp=1", bus.busy); end
        @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL busy_fall got=%b exp=0", bus.busy); end
    endtask

    task automatic test_write();
        bytes_t b, got;
        b = '{default: 8'h00};
        b[0] = 8'h05; b[1] = 8'h11; b[2] = 8'h22;
        run_frame(3, b, 8, got);
        n_cmp++; if (got[0] !== 8'hA5) begin n_err++; $display("FAIL wr_status got=%h exp=a5", got[0]); end
        n_cmp++; if (we_addr_q.size() != 2) begin n_err++; $display("FAIL wr_count got=%0d exp=2", we_addr_q.size()); end
        n_cmp++; if ({we_addr_q[0], we_data_q[0], we_addr_q[1], we_data_q[1]} !== {7'h05, 8'h11, 7'h06, 8'h22}) begin
            n_err++; $display("FAIL wr_beats got=%h/%h %h/%h exp=05/11 06/22", we_addr_q[0], we_data_q[0], we_addr_q[1], we_data_q[1]);
        end
        n_cmp++; if (re_addr_q.size() != 0) begin n_err++; $display("FAIL wr_no_read got=%0d exp=0", re_addr_q.size()); end
    endtask

    task automatic test_read();
        bytes_t b, got;
        b = '{default: 8'h00};
        b[0] = 8'h83;
        rsp_delay = 2;
        rd_off    = 8'h40;
        run_frame(3, b, 8, got);
        n_cmp++; if ({got[0], got[1], got[2]} !== {8'hA5, 8'h43, 8'h44}) begin
            n_err++; $display("FAIL rd_host got=%h %h %h exp=a5 43 44", got[0], got[1], got[2]);
        end
        n_cmp++; if (re_addr_q.size() != 3) begin n_err++; $display("FAIL rd_count got=%0d exp=3", re_addr_q.size()); end
        n_cmp++; if ({re_addr_q[0], re_addr_q[1], re_addr_q[2]} !== {7'h03, 7'h04, 7'h05}) begin
            n_err++; $display("FAIL rd_addrs got=%h %h %h exp=03 04 05", re_addr_q[0], re_addr_q[1], re_addr_q[2]);
        end
        n_cmp++; if (bus.err_timeout !== 1'b0) begin n_err++; $display("FAIL rd_err got=%b exp=0", bus.err_timeout); end
    endtask

    task automatic test_wrap();
        bytes_t b, got;
        b = '{default: 8'h00};
        b[0] = 8'h7F; b[1] = 8'($urandom); b[2] = 8'($urandom);
        run_frame(3, b, 9, got);
        n_cmp++; if ({we_addr_q[0], we_data_q[0], we_addr_q[1], we_data_q[1]} !== {7'h7F, b[1], 7'h00, b[2]}) begin
            n_err++; $display("FAIL wrap got=%h/%h %h/%h exp=7f/%h 00/%h", we_addr_q[0], we_data_q[0], we_addr_q[1], we_data_q[1], b[1], b[2]);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] g;
        rsp_delay = 0;
        frame_begin();
        xfer(8'h90, 8, g);
        repeat (5) @(negedge clk);
        n_cmp++; if ({bus.tx_data, bus.err_timeout} !== {8'hA5, 1'b0}) begin
            n_err++; $display("FAIL tmo_early got=%h/%b exp=a5/0", bus.tx_data, bus.err_timeout);
        end
        @(negedge clk);
        n_cmp++; if ({bus.tx_data, bus.err_timeout} !== {8'hFF, 1'b1}) begin
            n_err++; $display("FAIL tmo_fill got=%h/%b exp=ff/1", bus.tx_data, bus.err_timeout);
        end
        frame_end();
        n_cmp++; if (bus.err_timeout !== 1'b1) begin n_err++; $display("FAIL tmo_sticky got=%b exp=1", bus.err_timeout); end
        @(posedge clk); #1 bus.ssel = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (bus.err_timeout !== 1'b0) begin n_err++; $display("FAIL tmo_clear got=%b exp=0", bus.err_timeout); end
        @(posedge clk); #1 bus.ssel = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_abort();
        logic [7:0] g;
        frame_begin();
        xfer(8'h20, 8, g);
        repeat (12) @(posedge clk);
        #1 bus.ssel = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if ({bus.busy, bus.tx_data} !== {1'b0, 8'hA5}) begin
            n_err++; $display("FAIL abort_idle got=%b/%h exp=0/a5", bus.busy, bus.tx_data);
        end
        n_cmp++; if (we_addr_q.size() != 0) begin n_err++; $display("FAIL abort_no_we got=%0d exp=0", we_addr_q.size()); end
        n_cmp++; if (bus.reg_addr !== 7'h20) begin n_err++; $display("FAIL abort_addr got=%h exp=20", bus.reg_addr); end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_fast_host();
        logic [7:0] g;
        logic [6:0] a;
        a         = 7'($urandom);
        rsp_delay = 4;
        rd_off    = 8'($urandom);
        frame_begin();
        xfer({1'b1, a}, 8, g);
        xfer(8'h00, 1, g);
        repeat (10) @(posedge clk);
        @(negedge clk);
        n_cmp++; if ({bus.tx_data, bus.err_timeout} !== {rd_val(a + 7'd1), 1'b1}) begin
            n_err++; $display("FAIL fast_host got=%h/%b exp=%h/1", bus.tx_data, bus.err_timeout, rd_val(a + 7'd1));
        end
        n_cmp++; if ({re_addr_q.size() == 2, re_addr_q[0], re_addr_q[1]} !== {1'b1, a, a + 7'd1}) begin
            n_err++; $display("FAIL fast_reads got=%0d:%h %h exp=2:%h %h", re_addr_q.size(), re_addr_q[0], re_addr_q[1], a, a + 7'd1);
        end
        frame_end();
    endtask

    task automatic test_async_reset();
        logic [7:0] g;
        rsp_delay = 4;
        frame_begin();
        xfer(8'h95, 8, g);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({bus.tx_data, bus.reg_addr, bus.reg_wdata, bus.reg_we, bus.reg_re, bus.busy, bus.err_timeout} !==
                     {8'hA5, 7'h00, 8'h00, 4'b0000}) begin
            n_err++; $display("FAIL areset got=%h %h %h %b%b%b%b exp=a5 00 00 0000", bus.tx_data, bus.reg_addr,
                              bus.reg_wdata, bus.reg_we, bus.reg_re, bus.busy, bus.err_timeout);
        end
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++; if ({bus.tx_data, bus.err_timeout} !== {8'hA5, 1'b0}) begin
            n_err++; $display("FAIL areset_late_rvalid got=%h/%b exp=a5/0", bus.tx_data, bus.err_timeout);
        end
        frame_end();
    endtask

    task automatic test_random();
        bytes_t     b, got;
        logic       rw, tmo;
        logic [6:0] a;
        int         n, dsel;
        for (int f = 0; f < 12; f++) begin
            rw        = 1'($urandom_range(0, 1));
            a         = 7'($urandom);
            n         = $urandom_range(1, 5);
            dsel      = $urandom_range(0, 5);
            rsp_delay = (dsel == 5) ? 6 : ((dsel == 4) ? 0 : dsel + 1);
            rd_off    = 8'($urandom);
            tmo       = rw && ((rsp_delay == 0) || (rsp_delay > 4));
            b         = '{default: 8'h00};
            b[0]      = {rw, a};
            for (int i = 1; i <= n; i++) b[i] = 8'($urandom);
            run_frame(n + 1, b, $urandom_range(8, 12), got);
            n_cmp++; if (got[0] !== 8'hA5) begin n_err++; $display("FAIL rnd%0d_status got=%h exp=a5", f, got[0]); end
            n_cmp++; if (bus.err_timeout !== tmo) begin n_err++; $display("FAIL rnd%0d_err got=%b exp=%b", f, bus.err_timeout, tmo); end
            if (rw) begin
                n_cmp++; if (re_addr_q.size() != n + 1 || we_addr_q.size() != 0) begin
                    n_err++; $display("FAIL rnd%0d_rd_count got=%0d/%0d exp=%0d/0", f, re_addr_q.size(), we_addr_q.size(), n + 1);
                end
                for (int k = 0; k <= n; k++) begin
                    n_cmp++; if (re_addr_q[k] !== a + 7'(k)) begin
                        n_err++; $display("FAIL rnd%0d_re%0d got=%h exp=%h", f, k, re_addr_q[k], a + 7'(k));
                    end
                end
                for (int k = 1; k <= n; k++) begin
                    n_cmp++; if (got[k] !== (tmo ? 8'hFF : rd_val(a + 7'(k - 1)))) begin
                        n_err++; $display("FAIL rnd%0d_host%0d got=%h exp=%h", f, k, got[k], tmo ? 8'hFF : rd_val(a + 7'(k - 1)));
                    end
                end
            end else begin
                n_cmp++; if (we_addr_q.size() != n || re_addr_q.size() != 0) begin
                    n_err++; $display("FAIL rnd%0d_wr_count got=%0d/%0d exp=%0d/0", f, we_addr_q.size(), re_addr_q.size(), n);
                end
                for (int k = 0; k < n; k++) begin
                    n_cmp++; if ({we_addr_q[k], we_data_q[k]} !== {a + 7'(k), b[k + 1]}) begin
                        n_err++; $display("FAIL rnd%0d_we%0d got=%h/%h exp=%h/%h", f, k, we_addr_q[k], we_data_q[k], a + 7'(k), b[k + 1]);
                    end
                end
            end
        end
        n_cmp++; if (both_cnt != 0) begin n_err++; $display("FAIL we_re_overlap got=%0d exp=0", both_cnt); end
    endtask

    initial begin
        bus.ssel          = 1'b1;
        bus.byte_received = 1'b0;
        bus.rx_data       = 8'h00;
        bus.data_needed   = 1'b0;
        test_reset();
        test_busy();
        test_write();
        test_read();
        test_wrap();
        test_timeout();
        test_abort();
        test_fast_host();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
